// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the iterative signed multiplier.
// Holds the controller state encoding and the counter width helper.
package seq_mult_pkg;

   localparam int SEQ_N_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      MUL,
      FIX
   } state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/seq_signed_mult_if.sv
// Start/done handshake bundle between operand registers and multiplier.
// master drives operands and start; slave returns busy, done and product.
interface seq_signed_mult_if
   import seq_mult_pkg::*;
#(
   parameter int N = SEQ_N_DEF
) ();

   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] p;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  p
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output p
   );

endinterface

// File: rtl/sign_mag_conv.sv
// Two's-complement to magnitude: invert by sign, then add the sign bit
// through a half-adder ripple so -2^(N-1) maps to 2^(N-1) unsigned.
module sign_mag_conv #(
   parameter int N = 8
) (
   input  logic [N-1:0] x,
   output logic [N-1:0] mag
);

   logic         s;
   logic [N-1:0] t;
   logic [N-1:0] c;

   assign s = x[N-1];

   always_comb begin
      t   = '0;
      c   = '0;
      mag = '0;
      c[0] = s;
      for (int i = 0; i < N; i++) begin
         t[i]   = x[i] ^ s;
         mag[i] = t[i] ^ c[i];
         if (i < N-1) begin
            c[i+1] = t[i] & c[i];
         end
      end
   end

endmodule

// File: rtl/seq_signed_mult.sv
// Iterative signed multiplier: sign-magnitude shift-add over N cycles.
// Define SEQ_MULT_EARLY_TERM_EN to stop once the multiplier runs out of ones.
module seq_signed_mult
   import seq_mult_pkg::*;
#(
   parameter int N = SEQ_N_DEF
) (
   input logic              clk,
   input logic              reset_n,
   seq_signed_mult_if.slave bus
);

   localparam int CW = cnt_w(N);
   localparam int PW = 2*N;

   state_t state_q;
   state_t state_n;

   logic [N-1:0]  a_q;
   logic [N-1:0]  b_q;
   logic [N-1:0]  mag_a_c;
   logic [N-1:0]  mag_b_c;
   logic [N-1:0]  mag_a_q;
   logic [N-1:0]  mag_b_q;
   logic          neg_q;
   logic [PW-1:0] acc_q;
   logic [PW-1:0] addend;
   logic [PW-1:0] p_fix;
   logic [PW-1:0] p_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          done_q;
   logic          accept;
   logic          last_it;

   sign_mag_conv #(.N(N)) u_conv_a (
      .x   (a_q),
      .mag (mag_a_c)
   );

   sign_mag_conv #(.N(N)) u_conv_b (
      .x   (b_q),
      .mag (mag_b_c)
   );

`ifdef SEQ_MULT_EARLY_TERM_EN
   // Shifted multiplier about to become zero: no further partial products.
   assign last_it = (cnt_q == CW'(N-1)) || (mag_b_q[N-1:1] == '0);
`else
   assign last_it = (cnt_q == CW'(N-1));
`endif

   assign addend = {{N{1'b0}}, mag_a_q} << cnt_q;
   assign p_fix  = neg_q ? (~acc_q + PW'(1)) : acc_q;

   always_comb begin
      state_n = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_n = LOAD;
            end
         end
         LOAD: state_n = MUL;
         MUL: begin
            if (last_it) begin
               state_n = FIX;
            end
         end
         FIX: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         // Registered so busy covers the cycles after LOAD through FIX.
         busy_q  <= (state_n == MUL) || (state_n == FIX);
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q <= bus.a;
                  b_q <= bus.b;
               end
            end
            LOAD: begin
               mag_a_q <= mag_a_c;
               mag_b_q <= mag_b_c;
               neg_q   <= a_q[N-1] ^ b_q[N-1];
               acc_q   <= '0;
               cnt_q   <= '0;
            end
            MUL: begin
               if (mag_b_q[0]) begin
                  acc_q <= acc_q + addend;
               end
               mag_b_q <= mag_b_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
            end
            FIX: begin
               p_q    <= p_fix;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.p    = p_q;

endmodule
